pci_bus_master: RTL

//  Initiator-side agent that sits on the other end of the REQ/GNT handshake from the

---
 rtl/pci_bus_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pci_bus_master.sv
// PCI initiator agent: REQ/GNT handshake, one address phase, then a FRAME/IRDY burst against TRDY/STOP/DEVSEL.
// Latency: REQ and xfer_ack one cycle after xfer_req; ADDR one cycle after GNT with an idle bus; data_xfer is combinational.
// Backpressure: TRDY low stretches a data phase; STOP, a lost GNT or no DEVSEL end the tenure early.
module pci_bus_master #(
    parameter int LEN_W     = 4,
    parameter int DEVSEL_TO = 5,
    parameter int LAT_TIMER = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             xfer_req,
    input  logic [LEN_W-1:0] xfer_len,
    output logic             xfer_ack,
    output logic             xfer_done,
    output logic             xfer_err,
    output logic             data_xfer,
    output logic             addr_phase,
    output logic             REQ,
    input  logic             GNT,
    output logic             FRAME,
    output logic             IRDY,
    input  logic             bus_frame,
    input  logic             bus_irdy,
    input  logic             TRDY,
    input  logic             STOP,
    input  logic             DEVSEL
);

    localparam int LAT_W = $clog2(LAT_TIMER + 1);
    localparam int DEV_W = $clog2(DEVSEL_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_ADDR,
        S_DATA,
        S_TURN
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] remaining, rem_nx, rem_dec;
    logic [LAT_W-1:0] lat_cnt, lat_nx;
    logic [DEV_W-1:0] dev_cnt, dev_nx;
    logic             dev_seen, dev_seen_nx;
    logic             stop_end, stop_end_nx;
    logic             resume, resume_nx;
    logic             req_nx, frame_nx, irdy_nx, addr_nx, ack_nx, done_nx, err_nx;
    logic             lat_exp, on_bus, abort_now, complete, lat_yield, to_turn;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            remaining  <= '0;
            lat_cnt    <= '0;
            dev_cnt    <= '0;
            dev_seen   <= 1'b0;
            stop_end   <= 1'b0;
            resume     <= 1'b0;
            REQ        <= 1'b0;
            FRAME      <= 1'b0;
            IRDY       <= 1'b0;
            addr_phase <= 1'b0;
            xfer_ack   <= 1'b0;
            xfer_done  <= 1'b0;
            xfer_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            remaining  <= rem_nx;
            lat_cnt    <= lat_nx;
            dev_cnt    <= dev_nx;
            dev_seen   <= dev_seen_nx;
            stop_end   <= stop_end_nx;
            resume     <= resume_nx;
            REQ        <= req_nx;
            FRAME      <= frame_nx;
            IRDY       <= irdy_nx;
            addr_phase <= addr_nx;
            xfer_ack   <= ack_nx;
            xfer_done  <= done_nx;
            xfer_err   <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        rem_nx      = remaining;
        lat_nx      = lat_cnt;
        dev_nx      = dev_cnt;
        dev_seen_nx = dev_seen;
        stop_end_nx = stop_end;
        resume_nx   = resume;
        req_nx      = REQ;
        frame_nx    = FRAME;
        irdy_nx     = IRDY;
        addr_nx     = 1'b0;
        ack_nx      = 1'b0;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        to_turn     = 1'b0;

        rem_dec   = (remaining != '0) ? remaining - LEN_W'(1) : remaining;
        lat_exp   = (lat_cnt >= LAT_W'(LAT_TIMER));
        on_bus    = (state == S_ADDR) || (state == S_DATA);
        abort_now = on_bus && !dev_seen && !DEVSEL && (dev_cnt == DEV_W'(DEVSEL_TO - 1));
        // The cycle after STOP is the FRAME-low handoff cycle; nothing moves in it.
        complete  = (state == S_DATA) && IRDY && TRDY && !stop_end && !abort_now;
        lat_yield = FRAME && lat_exp && !GNT;

        if (on_bus) begin
            if (!lat_exp) begin
                lat_nx = lat_cnt + LAT_W'(1);
            end
            if (DEVSEL) begin
                dev_seen_nx = 1'b1;
            end else if (!dev_seen) begin
                dev_nx = dev_cnt + DEV_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (xfer_req) begin
                    rem_nx   = (xfer_len == '0) ? LEN_W'(1) : xfer_len;
                    ack_nx   = 1'b1;
                    req_nx   = 1'b1;
                    state_nx = S_REQ_WAIT;
                end
            end
            S_REQ_WAIT: begin
                if (GNT && !bus_frame && !bus_irdy) begin
                    state_nx    = S_ADDR;
                    frame_nx    = 1'b1;
                    addr_nx     = 1'b1;
                    lat_nx      = '0;
                    dev_nx      = '0;
                    dev_seen_nx = 1'b0;
                    stop_end_nx = 1'b0;
                    resume_nx   = 1'b0;
                end
            end
            S_ADDR: begin
                if (abort_now) begin
                    to_turn = 1'b1;
                    done_nx = 1'b1;
                    err_nx  = 1'b1;
                    rem_nx  = '0;
                end else begin
                    state_nx = S_DATA;
                    req_nx   = 1'b0;
                    irdy_nx  = 1'b1;
                    frame_nx = (remaining > LEN_W'(1));
                end
            end
            S_DATA: begin
                if (abort_now) begin
                    to_turn = 1'b1;
                    done_nx = 1'b1;
                    err_nx  = 1'b1;
                    rem_nx  = '0;
                end else if (stop_end) begin
                    to_turn   = 1'b1;
                    resume_nx = 1'b1;
                end else if (complete) begin
                    rem_nx = rem_dec;
                    if (!FRAME) begin
                        // Final phase done: either the burst is finished or the tenure was cut short.
                        to_turn = 1'b1;
                        if (rem_dec == '0) begin
                            done_nx = 1'b1;
                        end else begin
                            resume_nx = 1'b1;
                        end
                    end else if (STOP) begin
                        frame_nx    = 1'b0;
                        stop_end_nx = 1'b1;
                    end else begin
                        frame_nx = (rem_dec > LEN_W'(1)) && !lat_yield;
                    end
                end else if (STOP) begin
                    if (FRAME) begin
                        frame_nx    = 1'b0;
                        stop_end_nx = 1'b1;
                    end else begin
                        to_turn   = 1'b1;
                        resume_nx = 1'b1;
                    end
                end else if (lat_yield) begin
                    frame_nx = 1'b0;
                end
            end
            S_TURN: begin
                if (resume) begin
                    state_nx  = S_REQ_WAIT;
                    req_nx    = 1'b1;
                    resume_nx = 1'b0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (to_turn) begin
            state_nx    = S_TURN;
            frame_nx    = 1'b0;
            irdy_nx     = 1'b0;
            req_nx      = 1'b0;
            stop_end_nx = 1'b0;
        end
    end

    assign data_xfer = complete;

endmodule
